// File: rtl/systolic_skew_feeder.sv
// Purpose: drains N row FIFOs into the west edge of a systolic array, with row i starting i steps after row 0.
// Latency: first read enable 1 cycle after start is accepted; each datum reaches the array 1 cycle after its read.
// Backpressure: if any scheduled row's FIFO is empty, no row reads that cycle, so the diagonal skew is kept.
module systolic_skew_feeder #(
    parameter int N      = 4,
    parameter int nbits  = 16,
    parameter int MAXLEN = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [$clog2(MAXLEN+1)-1:0]    len_i,
    output logic                           busy_o,
    output logic                           done_o,
    input  logic [N-1:0]                   fifo_empty_i,
    output logic [N-1:0]                   fifo_ren_o,
    input  logic [N*nbits-1:0]             fifo_q_i,
    output logic [N-1:0]                   out_val_o,
    output logic [N*nbits-1:0]             out_data_o
);

    localparam int LW   = $clog2(MAXLEN+1);
    localparam int TMAX = MAXLEN + N - 2;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [LW-1:0]   len_q, len_d;
    logic [N-1:0]    out_val_q;
    logic [N-1:0]    sched;
    logic            stall;
    logic            last_step;
    logic [N-1:0]    ren;

    // Diagonal schedule: row i is active for L consecutive steps starting at step i.
    always_comb begin
        sched = '0;
        for (int i = 0; i < N; i++) begin
            sched[i] = (int'(t_q) >= i) && (int'(t_q) < i + int'(len_q));
        end
    end

    // Stall whenever a row that should read this step has nothing to give; reads are
    // suppressed in the reset cycle so no FIFO entry is consumed and then thrown away.
    always_comb begin
        stall     = (state_q == S_RUN) && |(sched & fifo_empty_i);
        last_step = (int'(t_q) == int'(len_q) + N - 2);
        ren       = '0;
        if (state_q == S_RUN && !stall && !rst) begin
            ren = sched;
        end
    end

    // Next-state logic: step counter advances only on unstalled RUN cycles.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    t_d   = '0;
                    len_d = (len_i > LW'(MAXLEN)) ? LW'(MAXLEN) : len_i;
                    state_d = (len_i == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (last_step) begin
                        state_d = S_FLUSH;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // State, counter and latched length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
        end
    end

    // Read data arrives one cycle after its enable, so valid is the enable delayed by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_q <= '0;
        end else begin
            out_val_q <= ren;
        end
    end

    // Forward FIFO data only on rows that actually read last cycle; other rows are zeroed.
    always_comb begin
        out_data_o = '0;
        for (int i = 0; i < N; i++) begin
            out_data_o[i*nbits +: nbits] = out_val_q[i] ? fifo_q_i[i*nbits +: nbits] : '0;
        end
    end

    assign fifo_ren_o = ren;
    assign out_val_o  = out_val_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FLUSH);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: models the row FIFOs as queues and predicts reads,
// valids, data, busy and done from a wavefront model (per-row read counts).
module tb_systolic_skew_feeder;

    localparam int N      = 4;
    localparam int NB     = 16;
    localparam int MAXLEN = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [4:0]      len_i;
    logic            busy_o;
    logic            done_o;
    logic [N-1:0]    fifo_empty;
    logic [N-1:0]    fifo_ren;
    logic [N*NB-1:0] fifo_q;
    logic [N-1:0]    out_val;
    logic [N*NB-1:0] out_data;

    systolic_skew_feeder #(.N(N), .nbits(NB), .MAXLEN(MAXLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fifo_empty_i (fifo_empty),
        .fifo_ren_o   (fifo_ren),
        .fifo_q_i     (fifo_q),
        .out_val_o    (out_val),
        .out_data_o   (out_data)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_FLUSH} mst_t;
    mst_t           ms = M_IDLE;
    int             mL = 0;
    int             mp = 0;
    int             mr [N];
    logic [N-1:0]   m_vld = '0;
    logic [NB-1:0]  m_dat [N];
    logic [NB-1:0]  q [N][$];
    int             checks = 0;
    int             passed = 0;
    int             dut_reads [N];
    logic           obs_done;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else passed++;
    endfunction

    task automatic topup();
        for (int i = 0; i < N; i++) while (q[i].size() < 24) q[i].push_back(NB'($urandom));
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic cycle(input logic s, input logic [4:0] l, input logic r, input logic [N-1:0] fe);
        logic [N-1:0]    want, exp_ren;
        logic            stall;
        logic [N*NB-1:0] exp_data;
        bit              all_done;
        @(negedge clk);
        rst = r; start_i = s; len_i = l;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = fe[i] || (q[i].size() == 0);
            fifo_q[i*NB +: NB] = m_vld[i] ? m_dat[i] : NB'($urandom);
        end
        #1;
        want = '0;
        for (int i = 0; i < N; i++) if (ms == M_RUN && mp >= i && mr[i] < mL) want[i] = 1'b1;
        stall   = |(want & fifo_empty);
        exp_ren = (r || stall) ? '0 : want;
        exp_data = '0;
        for (int i = 0; i < N; i++) if (m_vld[i]) exp_data[i*NB +: NB] = m_dat[i];
        if (fifo_ren !== exp_ren) $display("  ren detail: p=%0d L=%0d", mp, mL);
        if (fifo_ren !== exp_ren) begin checks++; $display("FAIL fifo_ren: got %b expected %b (t=%0t)", fifo_ren, exp_ren, $time); end
        else begin checks++; passed++; end
        chk("out_val",  64'(out_val), 64'(m_vld));
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("busy",     64'(busy_o), 64'(ms != M_IDLE));
        chk("done",     64'(done_o), 64'(ms == M_FLUSH));
        obs_done = done_o;
        for (int i = 0; i < N; i++) dut_reads[i] += int'(fifo_ren[i]);
        if (r) begin
            ms = M_IDLE; m_vld = '0;
        end else begin
            m_vld = exp_ren;
            for (int i = 0; i < N; i++) if (exp_ren[i]) m_dat[i] = q[i].pop_front();
            case (ms)
                M_IDLE: if (s) begin
                    mL = (int'(l) > MAXLEN) ? MAXLEN : int'(l);
                    mp = 0;
                    for (int i = 0; i < N; i++) mr[i] = 0;
                    ms = (mL == 0) ? M_FLUSH : M_RUN;
                end
                M_RUN: if (!stall) begin
                    all_done = 1;
                    for (int i = 0; i < N; i++) begin
                        mr[i] += int'(exp_ren[i]);
                        if (mr[i] != mL) all_done = 0;
                    end
                    mp++;
                    if (all_done) ms = M_FLUSH;
                end
                default: ms = M_IDLE;
            endcase
        end
    endtask

    task automatic start_run(input logic [4:0] l);
        topup();
        for (int i = 0; i < N; i++) dut_reads[i] = 0;
        cycle(1'b1, l, 1'b0, '0);
    endtask

    // Runs until the model returns to IDLE; cycle 0 is the first cycle after start.
    task automatic run_to_idle(input int stall_cyc, input logic [N-1:0] smask, input bit rnd,
                               input int restart_cyc, input logic [4:0] rlen,
                               output int done_at, output int ndone);
        logic [N-1:0] fe;
        bit fin;
        done_at = -1; ndone = 0; fin = 0;
        for (int n = 0; n < 200 && !fin; n++) begin
            fe = (n == stall_cyc) ? smask : '0;
            if (rnd) for (int i = 0; i < N; i++) fe[i] = ($urandom_range(0, 7) == 0);
            cycle(n == restart_cyc, (n == restart_cyc) ? rlen : 5'd0, 1'b0, fe);
            if (obs_done) begin
                if (done_at < 0) done_at = n;
                ndone++;
            end
            if (ms == M_IDLE) fin = 1;
        end
        if (!fin) chk("run_timeout", 64'(0), 64'(1));
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, 5'd0, 1'b0, '0);
    endtask

    task automatic test_basic();
        int da, nd;
        start_run(5'd3);
        run_to_idle(-1, '0, 0, -1, 5'd0, da, nd);
        chk("basic_done_cycle", 64'(da), 64'(6));
        chk("basic_done_count", 64'(nd), 64'(1));
        for (int i = 0; i < N; i++) chk("basic_reads", 64'(dut_reads[i]), 64'(3));
    endtask

    task automatic test_stall();
        int da, nd;
        start_run(5'd3);
        run_to_idle(2, 4'b0100, 0, -1, 5'd0, da, nd);
        chk("stall_done_cycle", 64'(da), 64'(7));
        chk("stall_done_count", 64'(nd), 64'(1));
    endtask

    task automatic test_len_zero();
        int da, nd;
        start_run(5'd0);
        run_to_idle(-1, '0, 0, -1, 5'd0, da, nd);
        chk("len0_done_cycle", 64'(da), 64'(0));
        for (int i = 0; i < N; i++) chk("len0_reads", 64'(dut_reads[i]), 64'(0));
    endtask

    task automatic test_restart_ignored();
        int da, nd;
        start_run(5'd3);
        run_to_idle(-1, '0, 0, 2, 5'd5, da, nd);
        chk("restart_done_cycle", 64'(da), 64'(6));
        chk("restart_done_count", 64'(nd), 64'(1));
    endtask

    task automatic test_reset_midrun();
        start_run(5'd3);
        cycle(1'b0, 5'd0, 1'b0, '0);
        cycle(1'b0, 5'd0, 1'b0, '0);
        cycle(1'b0, 5'd0, 1'b1, '0);
        cycle(1'b0, 5'd0, 1'b0, '0);
        cycle(1'b0, 5'd0, 1'b0, '0);
        test_basic();
    endtask

    task automatic test_maxlen();
        int da, nd;
        start_run(5'd16);
        run_to_idle(-1, '0, 0, -1, 5'd0, da, nd);
        chk("maxlen_done_cycle", 64'(da), 64'(19));
        for (int i = 0; i < N; i++) chk("maxlen_reads", 64'(dut_reads[i]), 64'(16));
        start_run(5'd20);
        run_to_idle(-1, '0, 0, -1, 5'd0, da, nd);
        chk("clamp_done_cycle", 64'(da), 64'(19));
        for (int i = 0; i < N; i++) chk("clamp_reads", 64'(dut_reads[i]), 64'(16));
    endtask

    task automatic test_random();
        int da, nd, l, exp_l;
        for (int k = 0; k < 25; k++) begin
            l = $urandom_range(0, 20);
            exp_l = (l > MAXLEN) ? MAXLEN : l;
            start_run(5'(l));
            run_to_idle(-1, '0, 1, $urandom_range(0, 12), 5'($urandom_range(1, 20)), da, nd);
            chk("rand_done_count", 64'(nd), 64'(1));
            for (int i = 0; i < N; i++) chk("rand_reads", 64'(dut_reads[i]), 64'(exp_l));
            if ($urandom_range(0, 2) == 0) cycle(1'b0, 5'd0, 1'b0, '0);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; len_i = '0; fifo_empty = '1; fifo_q = '0;
        for (int i = 0; i < N; i++) begin mr[i] = 0; m_dat[i] = '0; dut_reads[i] = 0; end
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_restart_ignored();
        test_reset_midrun();
        test_maxlen();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
